// File: rtl/tot_event_capture.sv
// tot_event_capture: time-over-threshold capture with timestamp, duration and saturation queued in a FIFO.
// Define TOT_DROP_COUNTER_EN to count dropped events on drop_count.
// Without it, drop_count is tied to 0.
module tot_event_capture #(
  parameter int TS_WIDTH   = 32,
  parameter int DUR_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          detect,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_WIDTH-1:0]           evt_timestamp,
  output logic [DUR_WIDTH-1:0]          evt_duration,
  output logic                          evt_saturated,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_WIDTH + DUR_WIDTH + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t               r_state;
  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_detect_q;
  logic [TS_WIDTH-1:0]  r_start_ts;
  logic [DUR_WIDTH-1:0] r_dur;
  logic                 r_sat;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_count;
  logic                 r_valid;
  logic                 r_overflow;
  logic [EW-1:0]        r_head;
  logic                 w_rise;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [EW-1:0]        w_wdata;
  logic [AW-1:0]        w_rd_next;
  logic [LW-1:0]        w_count_next;
  logic [LW-1:0]        w_after_pop;
  logic [EW-1:0]        w_head_next;
  assign w_rise       = detect & ~r_detect_q;
  assign w_push       = (r_state == ACTIVE) & enable & ~detect & (r_dur >= DUR_WIDTH'(MIN_WIDTH)) & ~clear;
  assign w_pop        = r_valid & evt_ready & ~clear;
  assign w_full       = r_count == LW'(FIFO_DEPTH);
  assign w_push_ok    = w_push & (~w_full | w_pop);
  assign w_drop       = w_push & w_full & ~w_pop;
  assign w_wdata      = {r_start_ts, r_dur, r_sat};
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_after_pop  = r_count - LW'(w_pop);
  assign w_count_next = w_after_pop + LW'(w_push_ok);
  // A push into an otherwise-empty FIFO bypasses memory so the head register sees it immediately
  assign w_head_next  = (w_after_pop == '0) ? w_wdata : r_mem[w_rd_next];
  assign evt_valid    = r_valid;
  assign fifo_level   = r_count;
  assign overflow     = r_overflow;
  assign {evt_timestamp, evt_duration, evt_saturated} = r_head;
  // Free-running timestamp and registered detect for edge finding; clear leaves both alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts       <= '0;
      r_detect_q <= 1'b0;
    end else begin
      r_ts       <= r_ts + 1'b1;
      r_detect_q <= detect;
    end
  end
  // Excursion tracker: enable low aborts, detect low ends the event, otherwise count with saturation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_start_ts <= '0;
      r_dur      <= '0;
      r_sat      <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
    end else if (r_state == IDLE) begin
      if (enable && w_rise) begin
        r_state    <= ACTIVE;
        r_start_ts <= r_ts;
        r_dur      <= DUR_WIDTH'(1);
        r_sat      <= 1'b0;
      end
    end else if (!enable || !detect) begin
      r_state <= IDLE;
    end else if (&r_dur) begin
      r_sat <= 1'b1;
    end else begin
      r_dur <= r_dur + 1'b1;
    end
  end
  // Event storage; only the write port lives here, the head is held in its own register
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_wdata;
  end
  // FIFO pointers, occupancy, sticky overflow and registered head entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= w_count_next != '0;
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop || w_push_ok) r_head <= w_head_next;
    end
  end
`ifdef TOT_DROP_COUNTER_EN
  logic [15:0] r_drop_count;
  assign drop_count = r_drop_count;
  // Saturating count of events lost to a full FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_drop_count <= '0;
    else if (clear) r_drop_count <= '0;
    else if (w_drop && !(&r_drop_count)) r_drop_count <= r_drop_count + 1'b1;
  end
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_tot_event_capture.sv
// tb_tot_event_capture: directed stimulus with a scoreboard queue checked by a handshake monitor.
module tb_tot_event_capture;
  logic        clk = 1'b0;
  logic        reset_n, enable, clear, detect, evt_ready;
  logic        evt_valid, evt_saturated, overflow;
  logic [7:0]  evt_timestamp;
  logic [3:0]  evt_duration;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic [7:0]  cnt;
  logic [12:0] q[$];
  int          checks = 0;
  int          errors = 0;
`ifdef TOT_DROP_COUNTER_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  tot_event_capture #(.TS_WIDTH(8), .DUR_WIDTH(4), .FIFO_DEPTH(8), .MIN_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .detect(detect),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_timestamp(evt_timestamp),
    .evt_duration(evt_duration), .evt_saturated(evt_saturated), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= 8'd0;
    else cnt <= cnt + 8'd1;

  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      logic [12:0] exp_e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got ts=%0d dur=%0d sat=%0d but none required", evt_timestamp, evt_duration, evt_saturated);
      end else begin
        exp_e = q.pop_front();
        if ({evt_timestamp, evt_duration, evt_saturated} !== exp_e) begin
          errors++;
          $display("FAIL sb_entry got ts=%0d dur=%0d sat=%0d required ts=%0d dur=%0d sat=%0d",
                   evt_timestamp, evt_duration, evt_saturated, exp_e[12:5], exp_e[4:1], exp_e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int len, input bit rec);
    logic [7:0] t;
    logic [3:0] d;
    t = cnt;
    d = (len > 15) ? 4'd15 : 4'(len);
    detect = 1'b1;
    repeat (len) step();
    detect = 1'b0;
    if (rec) q.push_back({t, d, len > 15});
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    for (int i = 0; i < 40 && evt_valid; i++) step();
    evt_ready = 1'b0;
    chk({name, "_valid"}, evt_valid, 0);
    chk({name, "_sb_left"}, q.size(), 0);
  endtask

  task automatic wait_ts(input logic [7:0] v);
    for (int i = 0; i < 300 && cnt != v; i++) step();
    chk("wait_ts", cnt, v);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; detect = 1'b0; evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_head", {evt_timestamp, evt_duration, evt_saturated}, 0);
    reset_n = 1'b1;
    // basic pulse at ts=10
    wait_ts(8'd10);
    pulse(5, 1);
    chk("basic_valid_end_cycle", evt_valid, 0);
    step();
    chk("basic_valid_next", evt_valid, 1);
    chk("basic_level", fifo_level, 1);
    chk("basic_ts", evt_timestamp, 10);
    chk("basic_dur", evt_duration, 5);
    drain("basic");
    // filter below MIN_WIDTH with a single-cycle gap
    pulse(2, 0);
    step();
    pulse(4, 1);
    step();
    step();
    chk("filter_level", fifo_level, 1);
    drain("filter");
    // overflow with 10 pulses into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      pulse(3, i < 8);
      step();
    end
    chk("ovf_level", fifo_level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, EXP_DROP);
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    // clear with 3 entries queued and overflow set
    for (int i = 0; i < 3; i++) begin
      pulse(3, 1);
      step();
    end
    chk("clr_level_before", fifo_level, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.delete();
    chk("clr_valid", evt_valid, 0);
    chk("clr_level", fifo_level, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_drop", drop_count, 0);
    // full FIFO with a pop in the event-end cycle
    for (int i = 0; i < 8; i++) begin
      pulse(3, 1);
      step();
    end
    chk("full_level", fifo_level, 8);
    pulse(3, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("fullpop_level", fifo_level, 8);
    chk("fullpop_overflow", overflow, 0);
    drain("fullpop");
    // duration saturation
    pulse(20, 1);
    step();
    chk("sat_dur", evt_duration, 15);
    chk("sat_flag", evt_saturated, 1);
    drain("sat");
    // timestamp wrap: event at 255, next event after wrap
    wait_ts(8'd255);
    pulse(3, 1);
    step();
    chk("wrap_ts", evt_timestamp, 255);
    pulse(3, 1);
    step();
    drain("wrap");
    // abort by dropping enable mid-pulse
    detect = 1'b1;
    repeat (4) step();
    enable = 1'b0;
    step();
    detect = 1'b0;
    step();
    enable = 1'b1;
    repeat (3) step();
    chk("abort_level", fifo_level, 0);
    chk("abort_valid", evt_valid, 0);
    // asynchronous reset mid-pulse with an entry queued
    pulse(4, 1);
    step();
    step();
    chk("prerst_valid", evt_valid, 1);
    detect = 1'b1;
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", evt_valid, 0);
    chk("arst_head", {evt_timestamp, evt_duration, evt_saturated}, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop", drop_count, 0);
    detect = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
